// File: rtl/jailbreak_bridge_decoder.sv
// jailbreak_bridge_decoder
//
// Routes APF bridge accesses to one of NUM_TARGETS register blocks by the
// 3-bit region field addr[SEL_LSB+2:SEL_LSB], and sequences reads so that
// at most one is outstanding. Every accepted read returns a response: the
// target's data, UNMAPPED_RDATA for a region with no target, or
// TIMEOUT_RDATA when the target stays silent for TIMEOUT wait cycles.
//
// Ports:
//   clk, reset_n          bridge clock, asynchronous active-low reset
//   up_addr               upstream address (region field selects the target)
//   up_wr, up_wr_data     single-cycle write strobe and data
//   up_rd                 single-cycle read strobe
//   up_rd_data(_valid)    read data and its single-cycle response pulse
//   dn_addr, dn_wr_data   registered address / write data, shared by targets
//   dn_wr, dn_rd          one-hot registered write / read strobes
//   dn_rd_data(_valid)    per-target read data (32 bits each) and valid pulses
//   clr_status            clears both sticky flags (a same-cycle set wins)
//   timeout_sticky        a read was abandoned on timeout
//   overrun_sticky        a read arrived while another was outstanding

module jailbreak_bridge_decoder #(
  parameter int unsigned NUM_TARGETS    = 4,
  parameter int unsigned SEL_LSB        = 16,
  parameter int unsigned TIMEOUT        = 16,
  parameter logic [31:0] TIMEOUT_RDATA  = 32'hDEAD_BEEF,
  parameter logic [31:0] UNMAPPED_RDATA = 32'hFFFF_FFFF
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [31:0]               up_addr,
  input  logic                      up_wr,
  input  logic [31:0]               up_wr_data,
  input  logic                      up_rd,
  output logic [31:0]               up_rd_data,
  output logic                      up_rd_data_valid,
  output logic [31:0]               dn_addr,
  output logic [31:0]               dn_wr_data,
  output logic [NUM_TARGETS-1:0]    dn_wr,
  output logic [NUM_TARGETS-1:0]    dn_rd,
  input  logic [NUM_TARGETS*32-1:0] dn_rd_data,
  input  logic [NUM_TARGETS-1:0]    dn_rd_data_valid,
  input  logic                      clr_status,
  output logic                      timeout_sticky,
  output logic                      overrun_sticky
);

  typedef enum logic [0:0] {StIdle, StWait} state_e;

  // Last wait_cnt value before the read is abandoned.
  localparam logic [7:0] TimeoutLast = 8'(TIMEOUT - 1);

  state_e                 state;
  logic [2:0]             rsel;
  logic [7:0]             wait_cnt;

  logic [2:0]             sel;
  logic                   mapped;
  logic [NUM_TARGETS-1:0] sel_onehot;
  logic [31:0]            rsp_data;
  logic                   rsp_valid;

  assign sel    = up_addr[SEL_LSB+2:SEL_LSB];
  assign mapped = (32'(sel) < NUM_TARGETS);

  // Region decode and response mux. sel_onehot is all-zero for an unmapped
  // region, so unmapped writes fall out with no strobe. Only the target that
  // owns the outstanding read (rsel) can complete it.
  always_comb begin
    sel_onehot = '0;
    rsp_data   = '0;
    rsp_valid  = 1'b0;
    for (int unsigned i = 0; i < NUM_TARGETS; i++) begin
      if (32'(sel) == i) begin
        sel_onehot[i] = 1'b1;
      end
      if (32'(rsel) == i) begin
        rsp_data  = dn_rd_data[32*i +: 32];
        rsp_valid = dn_rd_data_valid[i];
      end
    end
  end

  // Request stage, read FSM and sticky flags, all registered.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state            <= StIdle;
      rsel             <= '0;
      wait_cnt         <= '0;
      dn_addr          <= '0;
      dn_wr_data       <= '0;
      dn_wr            <= '0;
      dn_rd            <= '0;
      up_rd_data       <= '0;
      up_rd_data_valid <= 1'b0;
      timeout_sticky   <= 1'b0;
      overrun_sticky   <= 1'b0;
    end else begin
      // Writes never stall: forwarded whatever the read FSM is doing.
      dn_addr          <= up_addr;
      dn_wr_data       <= up_wr_data;
      dn_wr            <= up_wr ? sel_onehot : '0;
      dn_rd            <= '0;
      up_rd_data_valid <= 1'b0;

      // Cleared first so that a set event later in this block wins.
      if (clr_status) begin
        timeout_sticky <= 1'b0;
        overrun_sticky <= 1'b0;
      end

      unique case (state)
        StIdle: begin
          if (up_rd) begin
            if (mapped) begin
              dn_rd    <= sel_onehot;
              rsel     <= sel;
              wait_cnt <= '0;
              state    <= StWait;
            end else begin
              up_rd_data       <= UNMAPPED_RDATA;
              up_rd_data_valid <= 1'b1;
            end
          end
        end

        StWait: begin
          // A second read while one is outstanding is dropped, not queued.
          if (up_rd) begin
            overrun_sticky <= 1'b1;
          end
          // A response on the timeout cycle takes priority over the timeout.
          if (rsp_valid) begin
            up_rd_data       <= rsp_data;
            up_rd_data_valid <= 1'b1;
            state            <= StIdle;
          end else if (wait_cnt == TimeoutLast) begin
            up_rd_data       <= TIMEOUT_RDATA;
            up_rd_data_valid <= 1'b1;
            timeout_sticky   <= 1'b1;
            state            <= StIdle;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end

        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_jailbreak_bridge_decoder.sv
// Scoreboard bench for jailbreak_bridge_decoder: stimulus pushes expected
// read responses (data and arrival cycle); a monitor pops and compares on
// every up_rd_data_valid. A small target model answers dn_rd after a
// per-target latency (0 = never) and stores dn_wr data.

module tb_jailbreak_bridge_decoder;

  localparam int NT = 4;

  typedef struct {
    logic [31:0] data;
    int          at;
  } exp_t;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic [31:0]       up_addr = '0;
  logic              up_wr = 1'b0;
  logic [31:0]       up_wr_data = '0;
  logic              up_rd = 1'b0;
  logic [31:0]       up_rd_data;
  logic              up_rd_data_valid;
  logic [31:0]       dn_addr;
  logic [31:0]       dn_wr_data;
  logic [NT-1:0]     dn_wr;
  logic [NT-1:0]     dn_rd;
  logic [NT*32-1:0]  dn_rd_data;
  logic [NT-1:0]     dn_rd_data_valid;
  logic              clr_status = 1'b0;
  logic              timeout_sticky;
  logic              overrun_sticky;

  logic [31:0]       regs [NT] = '{default: 32'h0};
  int                lat [NT] = '{default: 0};
  int                cnt [NT] = '{default: 0};
  logic [NT-1:0]     model_valid = '0;
  logic [NT-1:0]     poke = '0;

  int                cyc = 0;
  int                n_checks = 0;
  int                n_fail = 0;
  exp_t              sb[$];

  jailbreak_bridge_decoder dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .up_addr          (up_addr),
    .up_wr            (up_wr),
    .up_wr_data       (up_wr_data),
    .up_rd            (up_rd),
    .up_rd_data       (up_rd_data),
    .up_rd_data_valid (up_rd_data_valid),
    .dn_addr          (dn_addr),
    .dn_wr_data       (dn_wr_data),
    .dn_wr            (dn_wr),
    .dn_rd            (dn_rd),
    .dn_rd_data       (dn_rd_data),
    .dn_rd_data_valid (dn_rd_data_valid),
    .clr_status       (clr_status),
    .timeout_sticky   (timeout_sticky),
    .overrun_sticky   (overrun_sticky)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Target model: strobe seen mid-cycle; valid driven lat cycles later.
  assign dn_rd_data_valid = model_valid | poke;
  always_comb begin
    dn_rd_data = '0;
    for (int i = 0; i < NT; i++) dn_rd_data[32*i +: 32] = regs[i];
  end

  always @(negedge clk) begin
    for (int i = 0; i < NT; i++) begin
      if (dn_wr[i]) regs[i] <= dn_wr_data;
      if (dn_rd[i] && lat[i] > 0) begin
        cnt[i]         <= lat[i];
        model_valid[i] <= 1'b0;
      end else if (cnt[i] > 0) begin
        cnt[i]         <= cnt[i] - 1;
        model_valid[i] <= (cnt[i] == 1);
      end else begin
        model_valid[i] <= 1'b0;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every upstream response must match the head of the scoreboard.
  always @(negedge clk) begin
    if (up_rd_data_valid) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_rsp: got response %h at cycle %0d, required none",
                 up_rd_data, cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("rsp_data", up_rd_data, e.data);
        check("rsp_cycle", 32'(cyc), 32'(e.at));
      end
    end
  end

  task automatic expect_rsp(input logic [31:0] data, input int lat_cycles);
    exp_t e;
    e.data = data;
    e.at   = cyc + lat_cycles;
    sb.push_back(e);
  endtask

  // Both tasks are entered at a negedge and return at the next one, when
  // the registered downstream strobes for the access are visible.
  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    up_addr    = a;
    up_wr_data = d;
    up_wr      = 1'b1;
    @(negedge clk);
    up_wr = 1'b0;
  endtask

  task automatic rd(input logic [31:0] a);
    up_addr = a;
    up_rd   = 1'b1;
    @(negedge clk);
    up_rd = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_rd_data"}, up_rd_data, 32'h0);
    check({tag, "_rd_valid"}, 32'(up_rd_data_valid), 32'h0);
    check({tag, "_dn_addr"}, dn_addr, 32'h0);
    check({tag, "_dn_wr_data"}, dn_wr_data, 32'h0);
    check({tag, "_dn_wr"}, 32'(dn_wr), 32'h0);
    check({tag, "_dn_rd"}, 32'(dn_rd), 32'h0);
    check({tag, "_timeout"}, 32'(timeout_sticky), 32'h0);
    check({tag, "_overrun"}, 32'(overrun_sticky), 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset with busy inputs: nothing may leak through.
    up_addr    = 32'h0001_0000;
    up_wr_data = 32'h5555_AAAA;
    up_wr      = 1'b1;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    up_wr   = 1'b0;
    reset_n = 1'b1;
    @(negedge clk);

    // Preload targets 0 and 3.
    wr(32'h0000_0000, 32'hC0DE_0000);
    wr(32'h0003_0000, 32'hCAFE_0003);
    @(negedge clk);

    // Write then read target 1 (one-cycle responder).
    lat[1] = 1;
    wr(32'h0001_0000, 32'h0000_00A5);
    check("wr_strobe", 32'(dn_wr), 32'h2);
    check("wr_addr", dn_addr, 32'h0001_0000);
    check("wr_data", dn_wr_data, 32'h0000_00A5);
    @(negedge clk);
    check("wr_strobe_off", 32'(dn_wr), 32'h0);
    expect_rsp(32'h0000_00A5, 3);
    rd(32'h0001_0000);
    check("rd_strobe", 32'(dn_rd), 32'h2);
    @(negedge clk);
    check("rd_strobe_off", 32'(dn_rd), 32'h0);
    repeat (4) @(negedge clk);

    // Silent target 2: timeout.
    lat[2] = 0;
    expect_rsp(32'hDEAD_BEEF, 17);
    rd(32'h0002_0000);
    check("rd_strobe_t2", 32'(dn_rd), 32'h4);
    repeat (18) @(negedge clk);
    check("timeout_set", 32'(timeout_sticky), 32'h1);
    clr_status = 1'b1;
    @(negedge clk);
    clr_status = 1'b0;
    check("timeout_clr", 32'(timeout_sticky), 32'h0);

    // Unmapped region 5: immediate all-ones, no strobes.
    expect_rsp(32'hFFFF_FFFF, 1);
    rd(32'h0005_0000);
    check("unmapped_rd", 32'(dn_rd), 32'h0);
    @(negedge clk);
    wr(32'h0005_0000, 32'h0000_0077);
    check("unmapped_wr", 32'(dn_wr), 32'h0);
    repeat (2) @(negedge clk);

    // Overrun: second read two cycles after the first is dropped.
    lat[0] = 5;
    expect_rsp(32'hC0DE_0000, 7);
    rd(32'h0000_0000);
    @(negedge clk);
    rd(32'h0000_0000);
    check("overrun_no_strobe", 32'(dn_rd), 32'h0);
    repeat (6) @(negedge clk);
    check("overrun_set", 32'(overrun_sticky), 32'h1);
    check("no_timeout_on_rsp", 32'(timeout_sticky), 32'h0);
    clr_status = 1'b1;
    @(negedge clk);
    clr_status = 1'b0;
    check("overrun_clr", 32'(overrun_sticky), 32'h0);

    // Stray valid from target 1 while waiting on target 3, and in IDLE.
    wr(32'h0001_0000, 32'h1234_5678);
    @(negedge clk);
    poke = 4'b0001;
    @(negedge clk);
    poke = 4'b0000;
    lat[3] = 4;
    expect_rsp(32'hCAFE_0003, 6);
    rd(32'h0003_0000);
    poke = 4'b0010;
    @(negedge clk);
    poke = 4'b0000;
    repeat (6) @(negedge clk);

    // Reset mid-WAIT: no response, late target valid ignored.
    lat[0] = 6;
    rd(32'h0000_0000);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    check_all_zero("midreset");
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (10) @(negedge clk);

    // FSM back in IDLE and accepting reads.
    expect_rsp(32'hFFFF_FFFF, 1);
    rd(32'h0007_0000);
    repeat (3) @(negedge clk);

    check("sb_drained", 32'(sb.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/jailbreak_bridge_decoder.md
# jailbreak_bridge_decoder

Address decoder and read sequencer between the APF bridge and the core's bridge-mapped register blocks (DIP switches, control and status registers). Each upstream access is routed to one of `NUM_TARGETS` targets by an address region field. At most one read is outstanding at a time, and every read returns a response even if its target stays silent. Writes are forwarded without stalling.

## Interface
- `NUM_TARGETS`, 4: number of downstream targets, 1..8.
- `SEL_LSB`, 16: LSB of the region field; the field is `addr[SEL_LSB+2:SEL_LSB]` (3 bits).
- `TIMEOUT`, 16: number of WAIT cycles before a read is abandoned, 2..255.
- `TIMEOUT_RDATA`, 32'hDEAD_BEEF: read data returned on timeout.
- `UNMAPPED_RDATA`, 32'hFFFF_FFFF: read data returned for a region >= `NUM_TARGETS`.

Ports:
- `clk`  in  1  bridge clock; the only clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `up_addr`  in  32  upstream address.
- `up_wr`  in  1  single-cycle write strobe.
- `up_wr_data`  in  32  write data.
- `up_rd`  in  1  single-cycle read strobe.
- `up_rd_data`  out  32  read data; valid with `up_rd_data_valid`.
- `up_rd_data_valid`  out  1  single-cycle read response pulse.
- `dn_addr`  out  32  registered address, shared by all targets.
- `dn_wr_data`  out  32  registered write data, shared by all targets.
- `dn_wr`  out  NUM_TARGETS  one-hot write strobes.
- `dn_rd`  out  NUM_TARGETS  one-hot read strobes.
- `dn_rd_data`  in  NUM_TARGETS*32  target read data; target i occupies bits `[32i+31:32i]`.
- `dn_rd_data_valid`  in  NUM_TARGETS  target response pulses.
- `clr_status`  in  1  clears both sticky flags.
- `timeout_sticky`  out  1  set when a read times out.
- `overrun_sticky`  out  1  set when a read is dropped.

## Operation
- Region decode: `sel = up_addr[SEL_LSB+2:SEL_LSB]`. The access is mapped if `sel < NUM_TARGETS`.
- Request stage, registered every cycle:
  - `dn_addr <= up_addr` and `dn_wr_data <= up_wr_data` unconditionally.
  - `dn_wr[sel] <= up_wr` if mapped; all other bits 0.
- Writes: forwarded in every state. An unmapped write is discarded silently.
- Read FSM, states IDLE and WAIT:
  - IDLE, mapped `up_rd`: `dn_rd[sel] <= 1`, capture `rsel <= sel`, clear `wait_cnt`, go to WAIT.
  - IDLE, unmapped `up_rd`: no downstream strobe. Next cycle `up_rd_data <= UNMAPPED_RDATA` with a valid pulse. Stay in IDLE.
  - WAIT, `dn_rd_data_valid[rsel]` high: `up_rd_data <= dn_rd_data[rsel]`, pulse valid, go to IDLE.
  - WAIT, no response and `wait_cnt == TIMEOUT-1`: return `TIMEOUT_RDATA`, pulse valid, set `timeout_sticky`, go to IDLE.
  - WAIT, otherwise: `wait_cnt` increments. The counter is 8 bits and never wraps, since `TIMEOUT <= 255`.
- Valid pulses on any target other than `rsel`, or any valid pulse while in IDLE, are ignored; none reaches upstream.
- `up_rd` while in WAIT: the read is dropped (no downstream strobe, no response) and `overrun_sticky` is set.
- `up_rd` and `up_wr` in the same cycle: both are forwarded to the same target, and the read follows the FSM rules above.
- A response and the timeout landing on the same cycle: the response wins and `timeout_sticky` is not set.
- Sticky flags: `clr_status` clears both. If a set event and `clr_status` occur in the same cycle, the set wins.

## Timing
- Reset values (asynchronous assert, synchronous-safe deassert):
  - All outputs 0, including `up_rd_data`, `dn_addr`, `dn_wr_data` and both sticky flags.
  - State IDLE, `wait_cnt` 0, `rsel` 0.
- Strobe latency: `up_wr`/`up_rd` at edge T gives `dn_wr`/`dn_rd` high for exactly the cycle after T (edge T+1).
- Read response: the first WAIT cycle is T+1. A target valid sampled at edge T+1+k gives `up_rd_data_valid` at edge T+2+k.
  - A target that registers its response one cycle after the strobe gives upstream valid at T+3.
- Timeout: upstream valid at edge T+1+TIMEOUT.
- Unmapped read: upstream valid at edge T+1.
- After any response the FSM is in IDLE. A new `up_rd` in the cycle that carries `up_rd_data_valid` is accepted.
- Reset mid-WAIT: the outstanding read is abandoned with no response. A late target valid after reset is ignored.

## Test plan
- Write 32'h0000_00A5 to 0x0001_0000, then read 0x0001_0000. Target 1 is a one-cycle-latency register. Expect `dn_wr = 4'b0010` for one cycle, `dn_rd = 4'b0010` for one cycle, and `up_rd_data_valid` at T+3 with data 32'h0000_00A5.
- Read target 2 with a target that never responds and `TIMEOUT=16`. Expect valid at T+17 with 32'hDEAD_BEEF and `timeout_sticky = 1`. Pulse `clr_status` and expect the flag to return to 0.
- Read address 0x0005_0000. Expect no `dn_rd` bit set and valid at T+1 with 32'hFFFF_FFFF. Write to the same address and expect no `dn_wr` bit set.
- Read target 0 with a 5-cycle responder and issue a second `up_rd` 2 cycles later. Expect exactly one upstream response, with target 0's data, and `overrun_sticky = 1`.
- Read target 3; before it responds, target 1 pulses valid with 32'h1234_5678. Expect that pulse ignored, and the response carries target 3's data.
- Assert `reset_n` low in WAIT, then have the target respond after release. Expect all outputs 0 during reset and no `up_rd_data_valid` after release.
